// File: rtl/div_unit_pkg.sv
// Shared divide-unit definitions: div_ctrl encoding (also used by the decoder)
// and the divider FSM state type.
package div_unit_pkg;

  localparam logic [1:0] DIV_OP  = 2'b00;
  localparam logic [1:0] DIVU_OP = 2'b01;
  localparam logic [1:0] REM_OP  = 2'b10;
  localparam logic [1:0] REMU_OP = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Bit 0 of div_ctrl selects the unsigned flavour of both DIV and REM.
  function automatic logic is_signed_op(input logic [1:0] ctrl);
    return !ctrl[0];
  endfunction

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift {rem,quot} left by one and
// subtract the divisor when the widened partial remainder allows it.
module div_unit_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quot,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quot_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // WIDTH+1 bits: diff[WIDTH] is the borrow, set when shifted < divisor.
  assign shifted   = {rem, quot[WIDTH-1]};
  assign diff      = shifted - {1'b0, divisor};
  assign rem_next  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quot_next = {quot[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 RV32M divider (DIV/DIVU/REM/REMU) for the EX stage.
// Magnitudes are divided unsigned; signs are fixed up when the result is shown.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             cache_stall_m,
  input  logic             div_en_e,
  input  logic [1:0]       div_ctrl_e,
  input  logic [WIDTH-1:0] src_a_e,
  input  logic [WIDTH-1:0] src_b_e,
  output logic             div_stall,
  output logic             div_valid_e,
  output logic [WIDTH-1:0] div_result_e,
  output div_state_t       div_state
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] quot_q, rem_q, divisor_q;
  logic [WIDTH-1:0] quot_nx, rem_nx;
  logic             rem_sel_q, quot_neg_q, rem_neg_q;
  logic             start, signed_op, div_zero, overflow;
  logic [WIDTH-1:0] a_abs, b_abs, quot_fix, rem_fix;

  assign start     = div_en_e && !flush;
  assign signed_op = is_signed_op(div_ctrl_e);
  assign div_zero  = (src_b_e == '0);
  assign overflow  = signed_op && (src_a_e == MIN_INT) && (src_b_e == '1);
  assign a_abs     = (signed_op && src_a_e[WIDTH-1]) ? -src_a_e : src_a_e;
  assign b_abs     = (signed_op && src_b_e[WIDTH-1]) ? -src_b_e : src_b_e;
  assign quot_fix  = quot_neg_q ? -quot_q : quot_q;
  assign rem_fix   = rem_neg_q ? -rem_q : rem_q;
  assign div_state = state_q;

  div_unit_step #(.WIDTH(WIDTH)) u_step (
    .rem       (rem_q),
    .quot      (quot_q),
    .divisor   (divisor_q),
    .rem_next  (rem_nx),
    .quot_next (quot_nx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Handshake: div_stall freezes IF/ID/DE and bubbles EX->MEM while high;
  // div_valid_e marks div_result_e for the cycle(s) spent in DONE, and the
  // instruction leaves EX on the edge that exits DONE (no cache stall).
  always_comb begin
    state_d      = state_q;
    div_stall    = 1'b0;
    div_valid_e  = 1'b0;
    div_result_e = '0;
    case (state_q)
      IDLE: begin
        div_stall = start;
        if (start) state_d = (div_zero || overflow) ? DONE : BUSY;
      end
      BUSY: begin
        div_stall = 1'b1;
        if (flush)                        state_d = IDLE;
        else if (count_q == CNT_W'(1))    state_d = DONE;
      end
      DONE: begin
        div_valid_e  = 1'b1;
        div_result_e = rem_sel_q ? rem_fix : quot_fix;
        if (flush || !cache_stall_m) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      divisor_q  <= '0;
      rem_sel_q  <= 1'b0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            rem_sel_q <= div_ctrl_e[1];
            count_q   <= CNT_W'(WIDTH);
            divisor_q <= b_abs;
            // Fast paths already hold final signed values, so no fixup.
            if (div_zero) begin
              quot_q     <= '1;
              rem_q      <= src_a_e;
              quot_neg_q <= 1'b0;
              rem_neg_q  <= 1'b0;
            end else if (overflow) begin
              quot_q     <= MIN_INT;
              rem_q      <= '0;
              quot_neg_q <= 1'b0;
              rem_neg_q  <= 1'b0;
            end else begin
              quot_q     <= a_abs;
              rem_q      <= '0;
              quot_neg_q <= signed_op && (src_a_e[WIDTH-1] ^ src_b_e[WIDTH-1]);
              rem_neg_q  <= signed_op && src_a_e[WIDTH-1];
            end
          end
        end
        BUSY: begin
          quot_q  <= quot_nx;
          rem_q   <= rem_nx;
          count_q <= count_q - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
